// File: rtl/register_write_arbiter.sv
// register_write_arbiter: shares the register-file write port between the
// primary writeback stage and the auxiliary speculative-pointer updater.
// Primary has fixed priority. Aux gets a starvation override after MAX_WAIT
// refused cycles. A single registered stage drives the wb_* outputs.
// Optional feature macro: REG_WRITE_ARB_STATS_EN adds conflict_count.
module register_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        p_valid,
    output logic        p_ready,
    input  logic [2:0]  p_reg_number,
    input  logic [2:0]  p_reg_size,
    input  logic [31:0] p_reg_data,
    input  logic        p_stack,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_reg_number,
    input  logic [2:0]  a_reg_size,
    input  logic [31:0] a_reg_data,
    input  logic        a_stack,
    output logic        wb_reg_en,
    output logic [2:0]  wb_reg_number,
    output logic [2:0]  wb_reg_size,
    output logic [31:0] wb_reg_data,
    output logic        wb_stack,
    output logic        grant_aux
`ifdef REG_WRITE_ARB_STATS_EN
    ,
    output logic [15:0] conflict_count
`endif
);

    localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic              w_grant_p;
    logic              w_grant_a;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_wb_reg_en;
    logic [2:0]        r_wb_reg_number;
    logic [2:0]        r_wb_reg_size;
    logic [31:0]       r_wb_reg_data;
    logic              r_wb_stack;
    logic              r_grant_aux;

    // Grant decision: flush blocks aux, same-register keeps primary first so
    // the aux value lands last, otherwise starvation override then priority.
    always_comb begin
        w_grant_p = 1'b0;
        w_grant_a = 1'b0;
        if (!reset) begin
            w_grant_p = 1'b0;
            w_grant_a = 1'b0;
        end else if (flush) begin
            w_grant_p = p_valid;
        end else if (p_valid && !a_valid) begin
            w_grant_p = 1'b1;
        end else if (a_valid && !p_valid) begin
            w_grant_a = 1'b1;
        end else if (p_valid && a_valid) begin
            if (a_reg_number == p_reg_number) begin
                w_grant_p = 1'b1;
            end else if (r_wait_cnt == LP_MAX_WAIT) begin
                w_grant_a = 1'b1;
            end else begin
                w_grant_p = 1'b1;
            end
        end
    end

    assign p_ready = w_grant_p;
    assign a_ready = w_grant_a;

    // Starvation counter: counts refused aux cycles, saturating at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (flush || !a_valid || w_grant_a) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != LP_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Output stage: one-cycle write beat per accepted request, fields held otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wb_reg_en     <= 1'b0;
            r_wb_reg_number <= '0;
            r_wb_reg_size   <= '0;
            r_wb_reg_data   <= '0;
            r_wb_stack      <= 1'b0;
            r_grant_aux     <= 1'b0;
        end else begin
            r_wb_reg_en <= w_grant_p | w_grant_a;
            if (w_grant_a) begin
                r_wb_reg_number <= a_reg_number;
                r_wb_reg_size   <= a_reg_size;
                r_wb_reg_data   <= a_reg_data;
                r_wb_stack      <= a_stack;
                r_grant_aux     <= 1'b1;
            end else if (w_grant_p) begin
                r_wb_reg_number <= p_reg_number;
                r_wb_reg_size   <= p_reg_size;
                r_wb_reg_data   <= p_reg_data;
                r_wb_stack      <= p_stack;
                r_grant_aux     <= 1'b0;
            end
        end
    end

    assign wb_reg_en     = r_wb_reg_en;
    assign wb_reg_number = r_wb_reg_number;
    assign wb_reg_size   = r_wb_reg_size;
    assign wb_reg_data   = r_wb_reg_data;
    assign wb_stack      = r_wb_stack;
    assign grant_aux     = r_grant_aux;

`ifdef REG_WRITE_ARB_STATS_EN
    logic [15:0] r_conflict_count;

    // Conflict statistics: cycles with both requesters valid outside flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_conflict_count <= '0;
        end else if (p_valid && a_valid && !flush) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign conflict_count = r_conflict_count;
`endif

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed testbench for register_write_arbiter (MAX_WAIT=4).
module tb_register_write_arbiter;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        p_valid;
    logic        p_ready;
    logic [2:0]  p_reg_number;
    logic [2:0]  p_reg_size;
    logic [31:0] p_reg_data;
    logic        p_stack;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_reg_number;
    logic [2:0]  a_reg_size;
    logic [31:0] a_reg_data;
    logic        a_stack;
    logic        wb_reg_en;
    logic [2:0]  wb_reg_number;
    logic [2:0]  wb_reg_size;
    logic [31:0] wb_reg_data;
    logic        wb_stack;
    logic        grant_aux;
`ifdef REG_WRITE_ARB_STATS_EN
    logic [15:0] conflict_count;
`endif

    int errors = 0;
    int checks = 0;

    register_write_arbiter #(.MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .p_valid(p_valid), .p_ready(p_ready), .p_reg_number(p_reg_number),
        .p_reg_size(p_reg_size), .p_reg_data(p_reg_data), .p_stack(p_stack),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg_number(a_reg_number),
        .a_reg_size(a_reg_size), .a_reg_data(a_reg_data), .a_stack(a_stack),
        .wb_reg_en(wb_reg_en), .wb_reg_number(wb_reg_number), .wb_reg_size(wb_reg_size),
        .wb_reg_data(wb_reg_data), .wb_stack(wb_stack), .grant_aux(grant_aux)
`ifdef REG_WRITE_ARB_STATS_EN
        , .conflict_count(conflict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_valid = 1'b0;
        a_valid = 1'b0;
        flush   = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0;
        p_valid = 1'b1; p_reg_number = 3'd1; p_reg_size = 3'd2; p_reg_data = 32'hAAAA_0001; p_stack = 1'b0;
        a_valid = 1'b1; a_reg_number = 3'd5; a_reg_size = 3'd1; a_reg_data = 32'hBBBB_0005; a_stack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL reset_p_ready: got %b expected 0", p_ready); end
            checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
            tick();
            checks++; if (wb_reg_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b expected 0", wb_reg_en); end
            checks++; if (grant_aux !== 1'b0) begin errors++; $display("FAIL reset_grant_aux: got %b expected 0", grant_aux); end
            checks++; if (wb_reg_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_reg_data); end
        end
        reset = 1'b1;
        #1;
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL post_reset_p_ready: got %b expected 1", p_ready); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL post_reset_a_ready: got %b expected 0", a_ready); end
        tick();
        checks++; if (wb_reg_en !== 1'b1) begin errors++; $display("FAIL post_reset_wb_en: got %b expected 1", wb_reg_en); end
        checks++; if (grant_aux !== 1'b0) begin errors++; $display("FAIL post_reset_grant_aux: got %b expected 0", grant_aux); end
        checks++; if (wb_reg_data !== 32'hAAAA_0001) begin errors++; $display("FAIL post_reset_wb_data: got %h expected aaaa0001", wb_reg_data); end
        idle();
    endtask

    task automatic test_primary();
        p_valid = 1'b1; p_reg_number = 3'd3; p_reg_size = 3'd4; p_reg_data = 32'hDEAD_BEEF; p_stack = 1'b0;
        #1;
        checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL prim_p_ready: got %b expected 1", p_ready); end
        tick();
        p_valid = 1'b0;
        checks++; if (wb_reg_en !== 1'b1) begin errors++; $display("FAIL prim_wb_en: got %b expected 1", wb_reg_en); end
        checks++; if (wb_reg_number !== 3'd3) begin errors++; $display("FAIL prim_wb_num: got %0d expected 3", wb_reg_number); end
        checks++; if (wb_reg_size !== 3'd4) begin errors++; $display("FAIL prim_wb_size: got %0d expected 4", wb_reg_size); end
        checks++; if (wb_reg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prim_wb_data: got %h expected deadbeef", wb_reg_data); end
        checks++; if (grant_aux !== 1'b0) begin errors++; $display("FAIL prim_grant_aux: got %b expected 0", grant_aux); end
        tick();
        checks++; if (wb_reg_en !== 1'b0) begin errors++; $display("FAIL prim_wb_en_drop: got %b expected 0", wb_reg_en); end
        checks++; if (wb_reg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL prim_wb_data_hold: got %h expected deadbeef", wb_reg_data); end
    endtask

    task automatic test_back_to_back();
        p_valid = 1'b1; p_reg_number = 3'd2; p_reg_size = 3'd3; p_stack = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            p_reg_data = 32'h1000_0000 + i;
            tick();
            checks++; if (wb_reg_en !== 1'b1) begin errors++; $display("FAIL b2b_wb_en[%0d]: got %b expected 1", i, wb_reg_en); end
            checks++; if (wb_reg_data !== 32'h1000_0000 + i) begin errors++; $display("FAIL b2b_wb_data[%0d]: got %h expected %h", i, wb_reg_data, 32'h1000_0000 + i); end
            checks++; if (wb_stack !== 1'b1) begin errors++; $display("FAIL b2b_wb_stack[%0d]: got %b expected 1", i, wb_stack); end
        end
        p_stack = 1'b0;
        idle();
    endtask

    task automatic test_starvation();
        p_valid = 1'b1; p_reg_number = 3'd0; p_reg_size = 3'd4; p_reg_data = 32'h0000_0011;
        a_valid = 1'b1; a_reg_number = 3'd4; a_reg_size = 3'd2; a_reg_data = 32'h0000_0044; a_stack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (p_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL starve_ready[%0d]: got p=%b a=%b expected p=1 a=0", i, p_ready, a_ready); end
            tick();
            checks++; if (wb_reg_en !== 1'b1 || grant_aux !== 1'b0) begin errors++; $display("FAIL starve_beat[%0d]: got en=%b aux=%b expected en=1 aux=0", i, wb_reg_en, grant_aux); end
        end
        #1;
        checks++; if (a_ready !== 1'b1 || p_ready !== 1'b0) begin errors++; $display("FAIL starve_override: got p=%b a=%b expected p=0 a=1", p_ready, a_ready); end
        tick();
        checks++; if (grant_aux !== 1'b1 || wb_reg_en !== 1'b1) begin errors++; $display("FAIL starve_aux_beat: got en=%b aux=%b expected en=1 aux=1", wb_reg_en, grant_aux); end
        checks++; if (wb_reg_number !== 3'd4 || wb_reg_data !== 32'h44 || wb_stack !== 1'b1) begin errors++; $display("FAIL starve_aux_fields: got num=%0d data=%h stack=%b expected 4 44 1", wb_reg_number, wb_reg_data, wb_stack); end
        #1;
        checks++; if (p_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL starve_resume: got p=%b a=%b expected p=1 a=0", p_ready, a_ready); end
        tick();
        checks++; if (grant_aux !== 1'b0 || wb_reg_data !== 32'h11) begin errors++; $display("FAIL starve_resume_beat: got aux=%b data=%h expected 0 11", grant_aux, wb_reg_data); end
        a_stack = 1'b0;
        idle();
    endtask

    task automatic test_same_reg();
        p_valid = 1'b1; p_reg_number = 3'd6; p_reg_size = 3'd4; p_reg_data = 32'h0000_0100;
        a_valid = 1'b1; a_reg_number = 3'd6; a_reg_size = 3'd4; a_reg_data = 32'h0000_0200;
        #1;
        checks++; if (p_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL same_first_ready: got p=%b a=%b expected p=1 a=0", p_ready, a_ready); end
        tick();
        p_valid = 1'b0;
        checks++; if (wb_reg_data !== 32'h100 || grant_aux !== 1'b0) begin errors++; $display("FAIL same_first_beat: got data=%h aux=%b expected 100 0", wb_reg_data, grant_aux); end
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL same_second_ready: got %b expected 1", a_ready); end
        tick();
        a_valid = 1'b0;
        checks++; if (wb_reg_data !== 32'h200 || grant_aux !== 1'b1 || wb_reg_number !== 3'd6) begin errors++; $display("FAIL same_second_beat: got data=%h aux=%b num=%0d expected 200 1 6", wb_reg_data, grant_aux, wb_reg_number); end
        tick();
        checks++; if (wb_reg_en !== 1'b0 || wb_reg_data !== 32'h200) begin errors++; $display("FAIL same_final: got en=%b data=%h expected 0 200", wb_reg_en, wb_reg_data); end
    endtask

    task automatic test_flush();
        int waited;
        bit seen;
        flush = 1'b1; p_valid = 1'b0;
        a_valid = 1'b1; a_reg_number = 3'd2; a_reg_data = 32'h0000_0055;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (a_ready !== 1'b0 || p_ready !== 1'b0) begin errors++; $display("FAIL flush_ready[%0d]: got p=%b a=%b expected 0 0", i, p_ready, a_ready); end
            tick();
            checks++; if (wb_reg_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en[%0d]: got %b expected 0", i, wb_reg_en); end
        end
        flush = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL flush_release_ready: got %b expected 1", a_ready); end
        tick();
        checks++; if (wb_reg_en !== 1'b1 || grant_aux !== 1'b1 || wb_reg_data !== 32'h55) begin errors++; $display("FAIL flush_release_beat: got en=%b aux=%b data=%h expected 1 1 55", wb_reg_en, grant_aux, wb_reg_data); end
        // Flush with both valid: primary only, and the starvation count restarts afterwards.
        flush = 1'b1; p_valid = 1'b1; p_reg_number = 3'd1; p_reg_data = 32'h0000_0077;
        a_reg_number = 3'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (p_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL flush_both[%0d]: got p=%b a=%b expected 1 0", i, p_ready, a_ready); end
            tick();
        end
        flush = 1'b0;
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 10) begin
            #1;
            if (a_ready === 1'b1) seen = 1'b1;
            tick();
            waited++;
        end
        checks++; if (!seen || waited !== 5) begin errors++; $display("FAIL flush_wait_restart: got seen=%b cycles=%0d expected seen=1 cycles=5", seen, waited); end
        idle();
    endtask

`ifdef REG_WRITE_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if (conflict_count !== 16'd0) begin errors++; $display("FAIL stats_reset: got %0d expected 0", conflict_count); end
        p_valid = 1'b1; p_reg_number = 3'd0;
        a_valid = 1'b1; a_reg_number = 3'd7;
        for (int i = 0; i < 7; i++) begin
            flush = (i == 3);
            tick();
        end
        idle();
        checks++; if (conflict_count !== 16'd6) begin errors++; $display("FAIL stats_count: got %0d expected 6", conflict_count); end
    endtask
`endif

    initial begin
        reset = 1'b0; flush = 1'b0;
        p_valid = 1'b0; p_reg_number = '0; p_reg_size = '0; p_reg_data = '0; p_stack = 1'b0;
        a_valid = 1'b0; a_reg_number = '0; a_reg_size = '0; a_reg_data = '0; a_stack = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_primary();
        test_back_to_back();
        test_starvation();
        test_same_reg();
        test_flush();
`ifdef REG_WRITE_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
Shares the single register-file write port between two requesters: the primary writeback stage (architectural results) and an auxiliary updater (speculative stack/ESI pointer updates issued ahead of writeback). Fixed priority to primary, starvation guard for aux, one registered output stage driving the register file's wb_reg_* inputs. Sits between the writeback stage / aux unit and the register access stage.

Parameters:
MAX_WAIT, 4, cycles aux may be refused while valid before it overrides primary priority (1..2^WAIT_W-1)
WAIT_W, 3, width of the starvation counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
flush  in  1  pipeline flush; cancels aux traffic only
p_valid  in  1  primary request valid
p_ready  out  1  primary request accepted this cycle
p_reg_number  in  3  primary target register
p_reg_size  in  3  primary write size
p_reg_data  in  32  primary write data
p_stack  in  1  primary write is a stack-pointer update
a_valid  in  1  aux request valid
a_ready  out  1  aux request accepted this cycle
a_reg_number  in  3  aux target register
a_reg_size  in  3  aux write size
a_reg_data  in  32  aux write data
a_stack  in  1  aux write is a stack-pointer update
wb_reg_en  out  1  register-file write enable
wb_reg_number  out  3  register-file write register
wb_reg_size  out  3  register-file write size
wb_reg_data  out  32  register-file write data
wb_stack  out  1  register-file stack flag
grant_aux  out  1  registered: current wb_* beat came from aux

Behaviour:
- Reset (reset==0 at clk edge): wb_reg_en=0, wb_reg_number/size/data/stack=0, grant_aux=0, wait_cnt=0. While reset==0, p_ready=a_ready=0 combinationally.
- Readies are combinational from valids, wait_cnt, flush; at most one asserted per cycle; a ready is asserted only when its valid is asserted.
- Grant rules, per cycle (first match wins):
  - flush=1: aux never granted; primary granted if p_valid.
  - only one valid: grant it.
  - both valid, a_reg_number==p_reg_number: grant primary (older architectural write lands first, aux overwrites next).
  - both valid, wait_cnt==MAX_WAIT: grant aux.
  - otherwise: grant primary.
- Latency: request accepted at edge N drives wb_* with wb_reg_en=1 during cycle N+1 for exactly one cycle; fields copied unmodified; grant_aux=1 iff source was aux. No accept at N -> wb_reg_en=0 in N+1; other wb_* fields hold last value.
- Register file never back-pressures; throughput one write per cycle.
- wait_cnt: cleared when flush=1, a_valid=0, or aux granted; else +1 when a_valid=1 and a_ready=0, saturating at MAX_WAIT.
- Requesters must hold fields stable while valid && !ready; arbiter does not buffer refused requests.
- Same-register rule may starve aux indefinitely if primary keeps writing the same register; accepted, primary stream is bounded by retirement.
- Flush during cycle N+1 does not cancel a beat already on wb_*.

Optional Feature:
REG_WRITE_ARB_STATS_EN: when defined, adds output conflict_count (16 bits): increments (wrapping) on each cycle where p_valid && a_valid && reset==1 and flush==0; cleared by reset. When undefined, port and counter are absent; all other behaviour identical.

Test Plan:
- Reset low 2 cycles with p_valid=a_valid=1 -> p_ready=a_ready=0, wb_reg_en=0, grant_aux=0 throughout; first cycle after release grants primary.
- Primary alone: p_reg_number=3, size=4, data=0xDEADBEEF at cycle N -> cycle N+1 wb_reg_en=1, wb_reg_number=3, wb_reg_data=0xDEADBEEF, grant_aux=0; N+2 wb_reg_en=0.
- Both valid continuously, different regs (p=0, a=4), MAX_WAIT=4 -> primary granted 4 cycles, aux granted 5th cycle (grant_aux=1 one cycle later), wait_cnt back to 0, primary resumes.
- Both valid, same reg 6 (p data 0x100, a data 0x200) -> primary beat 0x100 first, aux beat 0x200 next cycle; final written value 0x200.
- a_valid=1, p_valid=0, flush=1 for 3 cycles -> a_ready=0, wb_reg_en=0, wait_cnt=0; flush drops -> aux granted next cycle.
- With REG_WRITE_ARB_STATS_EN, 7 cycles of simultaneous valids (one under flush) -> conflict_count=6.
